div: RTL

- Sequential signed fixed-point divider with valid/ready handshakes; the inverse of the multiplier stage.
- Computes q = round((a · 2^SHIFT) / b) with Q_WIDTH signed saturation and flags overflow and divide-by-zero.
- Produces one quotient bit per cycle (restoring, magnitude-based).
- Sits in the datapath wherever normalisation needs division by a non-constant, such as gain or power normalisation, where low throughput is acceptable.

---
 rtl/div.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/div.sv
// Sequential signed fixed-point divider: q = round(a * 2^SHIFT / b), saturated to Q_WIDTH bits.
// Restoring division on magnitudes, one quotient bit per cycle, valid/ready on both sides.
module div #(
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned B_WIDTH = 16,
    parameter int unsigned Q_WIDTH = 16,
    parameter int unsigned SHIFT   = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [Q_WIDTH-1:0] q,
    output logic               err_ovf,
    output logic               err_dbz
);

    localparam int unsigned ITER = A_WIDTH + SHIFT + 1;
    localparam int unsigned CW   = $clog2(ITER);
    localparam int unsigned RW   = B_WIDTH + 1;

    localparam logic [ITER-1:0]    MAG_MAX = ITER'((64'd1 << (Q_WIDTH - 1)) - 64'd1);
    localparam logic [ITER-1:0]    MAG_MIN = ITER'(64'd1 << (Q_WIDTH - 1));
    localparam logic [Q_WIDTH-1:0] Q_MAX   = {1'b0, {(Q_WIDTH - 1){1'b1}}};
    localparam logic [Q_WIDTH-1:0] Q_MIN   = {1'b1, {(Q_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFinal, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [ITER-1:0]    dq_q, dq_d;
    logic [B_WIDTH-1:0] bmag_q, bmag_d;
    logic               neg_q, neg_d;
    logic               zero_b_q, zero_b_d;
    logic               a_neg_q, a_neg_d;
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_dbz_q, err_dbz_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;

    logic [A_WIDTH-1:0] amag;
    logic [RW:0]        trial;
    logic [RW:0]        bext;
    logic               qbit;
    logic [ITER-1:0]    mag;
    logic [Q_WIDTH-1:0] mag_lo;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        bmag_d    = bmag_q;
        neg_d     = neg_q;
        zero_b_d  = zero_b_q;
        a_neg_d   = a_neg_q;
        q_d       = q_q;
        err_ovf_d = err_ovf_q;
        err_dbz_d = err_dbz_q;
        qbit      = 1'b0;

        amag   = a[A_WIDTH-1] ? (~a + A_WIDTH'(1)) : a;
        // dq_q shifts dividend bits out of the top and quotient bits in at the bottom
        trial  = {rem_q, dq_q[ITER-1]};
        bext   = {2'b00, bmag_q};
        // Q2 holds one extra fractional bit; adding one then dropping it rounds half up
        mag    = ITER'(({1'b0, dq_q} + (ITER + 1)'(1)) >> 1);
        mag_lo = Q_WIDTH'(mag);

        case (state_q)
            StIdle: begin
                if (s_ready_q && s_valid) begin
                    bmag_d   = b[B_WIDTH-1] ? (~b + B_WIDTH'(1)) : b;
                    neg_d    = a[A_WIDTH-1] ^ b[B_WIDTH-1];
                    zero_b_d = (b == '0);
                    a_neg_d  = a[A_WIDTH-1];
                    rem_d    = '0;
                    dq_d     = {amag, {(SHIFT + 1){1'b0}}};
                    cnt_d    = CW'(ITER - 1);
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (trial >= bext) begin
                    rem_d = RW'(trial - bext);
                    qbit  = 1'b1;
                end else begin
                    rem_d = RW'(trial);
                end
                dq_d = {dq_q[ITER-2:0], qbit};
                if (cnt_q == '0) begin
                    state_d = StFinal;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFinal: begin
                err_dbz_d = 1'b0;
                if (zero_b_q) begin
                    q_d       = a_neg_q ? Q_MIN : Q_MAX;
                    err_ovf_d = 1'b0;
                    err_dbz_d = 1'b1;
                end else if (!neg_q && (mag > MAG_MAX)) begin
                    q_d       = Q_MAX;
                    err_ovf_d = 1'b1;
                end else if (neg_q && (mag > MAG_MIN)) begin
                    q_d       = Q_MIN;
                    err_ovf_d = 1'b1;
                end else begin
                    q_d       = neg_q ? (~mag_lo + Q_WIDTH'(1)) : mag_lo;
                    err_ovf_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are registered so s_valid/m_ready never reach an output directly
        s_ready_d = (state_d == StIdle);
        m_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            bmag_q    <= '0;
            neg_q     <= 1'b0;
            zero_b_q  <= 1'b0;
            a_neg_q   <= 1'b0;
            q_q       <= '0;
            err_ovf_q <= 1'b0;
            err_dbz_q <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            bmag_q    <= bmag_d;
            neg_q     <= neg_d;
            zero_b_q  <= zero_b_d;
            a_neg_q   <= a_neg_d;
            q_q       <= q_d;
            err_ovf_q <= err_ovf_d;
            err_dbz_q <= err_dbz_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign q       = q_q;
    assign err_ovf = err_ovf_q;
    assign err_dbz = err_dbz_q;

endmodule
